// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared FSM state type, register map and default widths for the APB initiator
package apb_master_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [3:0] NUMBER_IN_GROUP = 4'h0;
  localparam logic [3:0] DATE = 4'h4;
  localparam logic [3:0] SURNAME = 4'h8;
  localparam logic [3:0] NAME = 4'hC;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: command/response port plus APB bus of the initiator, widths set here
interface apb_master_if import apb_master_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic rsp_err;
  logic PSEL;
  logic PENABLE;
  logic PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic PREADY;
  modport master (
    input cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB initiator; define APB_MASTER_TIMEOUT_EN to abort stalled ACCESS phases
module apb_master import apb_master_pkg::*; #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input logic PCLK,
  input logic PRESET,
  apb_master_if.master bus
);
  state_t state;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be within 1..255");
  end
`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt;
`else
  assign bus.rsp_err = 1'b0;
`endif
  // a new command is taken when idle, or when the current ACCESS completes this cycle
  assign bus.cmd_ready = !PRESET && (state == IDLE || (state == ACCESS && bus.PREADY));
  // IDLE -> SETUP -> ACCESS sequencer with registered APB and response outputs
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      state <= IDLE;
      bus.PSEL <= 1'b0;
      bus.PENABLE <= 1'b0;
      bus.PWRITE <= 1'b0;
      bus.PADDR <= '0;
      bus.PWDATA <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      bus.rsp_err <= 1'b0;
      cnt <= '0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE:
          if (bus.cmd_valid) begin
            bus.PWRITE <= bus.cmd_write;
            bus.PADDR <= bus.cmd_addr;
            bus.PWDATA <= bus.cmd_wdata;
            bus.PSEL <= 1'b1;
            state <= SETUP;
          end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          state <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        ACCESS:
          if (bus.PREADY) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
            bus.PENABLE <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            bus.rsp_err <= 1'b0;
`endif
            if (bus.cmd_valid) begin
              bus.PWRITE <= bus.cmd_write;
              bus.PADDR <= bus.cmd_addr;
              bus.PWDATA <= bus.cmd_wdata;
              state <= SETUP;
            end else begin
              bus.PSEL <= 1'b0;
              state <= IDLE;
            end
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            bus.PSEL <= 1'b0;
            bus.PENABLE <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err <= 1'b1;
            bus.rsp_rdata <= '0;
            state <= IDLE;
          end else
            cnt <= cnt + 8'd1;
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed checks of the APB initiator against a transaction-level model and a stub register slave
module tb_apb_master;
  import apb_master_pkg::*;
  localparam int TO = 16;
  typedef struct {
    logic w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rdata;
    logic err;
    int cyc;
    int lat;
  } exp_t;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  apb_master_if bus();
  apb_master #(.TIMEOUT_CYCLES(TO)) dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus));
  always #5 PCLK = ~PCLK;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ph = -1;
  int n_rsp = 0;
  int last_lat = 0;
  int wait_n = 0;
  int wcnt = 0;
  logic stall = 1'b0;
  logic stray = 1'b0;
  logic [31:0] mem [4] = '{default: 32'h0};
  logic [31:0] shadow [4] = '{default: 32'h0};
  logic [31:0] last_rd = 32'h0;
  logic [31:0] rsp_log [$];
  exp_t q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // stub register slave: wait_n wait states, optional permanent stall, optional stray PREADY outside ACCESS
  assign bus.PREADY = stall ? 1'b0 : (bus.PSEL && bus.PENABLE) ? (wcnt == wait_n) : stray;
  assign bus.PRDATA = mem[bus.PADDR[3:2]];
  always @(posedge PCLK) begin
    wcnt <= (bus.PSEL && bus.PENABLE && !bus.PREADY) ? wcnt + 1 : 0;
    if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) mem[bus.PADDR[3:2]] <= bus.PWDATA;
  end

  // transaction model: every accepted command must be on the bus in order and answered once with the right data and timing
  always @(negedge PCLK) begin
    exp_t e;
    cyc++;
    if (PRESET) begin
      q.delete();
      ph = -1;
      last_rd = 32'h0;
      chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      if (cyc > 1) chk("rst_psel", 64'(bus.PSEL), 64'd0);
    end else begin
      if (bus.rsp_valid) begin
        rsp_log.push_back(bus.rsp_rdata);
        if (q.size() == 0) chk("rsp_spurious", 64'(bus.rsp_valid), 64'd0);
        else begin
          e = q.pop_front();
          last_lat = cyc - e.cyc;
          chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          chk("rsp_latency", 64'(last_lat), 64'(e.lat));
          last_rd = e.rdata;
          n_rsp++;
        end
        ph = 0;
      end else begin
        chk("rdata_hold", 64'(bus.rsp_rdata), 64'(last_rd));
        ph++;
      end
      chk("psel", 64'(bus.PSEL), 64'(q.size() != 0));
      chk("penable", 64'(bus.PENABLE), 64'(q.size() != 0 && ph >= 1));
      if (q.size() != 0) begin
        chk("paddr", 64'(bus.PADDR), 64'(q[0].a));
        chk("pwrite", 64'(bus.PWRITE), 64'(q[0].w));
        chk("pwdata", 64'(bus.PWDATA), 64'(q[0].d));
      end
      chk("cmd_ready", 64'(bus.cmd_ready), 64'(q.size() == 0 || (ph >= 1 && bus.PREADY)));
      if (bus.cmd_valid && bus.cmd_ready) begin
        e.w = bus.cmd_write;
        e.a = bus.cmd_addr;
        e.d = bus.cmd_wdata;
        e.cyc = cyc;
`ifdef APB_MASTER_TIMEOUT_EN
        e.err = stall;
        e.lat = stall ? 2 + TO : 3 + wait_n;
`else
        e.err = 1'b0;
        e.lat = 3 + wait_n;
`endif
        e.rdata = (e.w || e.err) ? 32'h0 : shadow[e.a[3:2]];
        if (e.w && !stall) shadow[e.a[3:2]] = e.d;
        if (q.size() == 0) ph = -1;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    int i = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr = a;
    bus.cmd_wdata = d;
    do begin
      @(negedge PCLK);
      i++;
    end while (!bus.cmd_ready && i < 300);
    if (!bus.cmd_ready) chk("handshake_bound", 64'(bus.cmd_ready), 64'd1);
    @(posedge PCLK);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int i = 0;
    do begin
      @(posedge PCLK);
      #1;
      i++;
    end while (q.size() != 0 && i < 400);
    chk("idle_bound", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int nr;
    int i;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = 32'h0;
    bus.cmd_wdata = 32'h0;
    repeat (3) @(posedge PCLK);
    #1;
    bus.cmd_valid = 1'b1;
    #1;
    chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("reset_outputs", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err}), 64'd0);
    chk("reset_paddr", 64'(bus.PADDR), 64'd0);
    chk("reset_pwdata", 64'(bus.PWDATA), 64'd0);
    chk("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    bus.cmd_valid = 1'b0;
    PRESET = 1'b0;
    @(posedge PCLK);
    #1;
    chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    wait_n = 1;
    send(1'b1, 32'(DATE), 32'h15032024);
    wait_idle();
    chk("write_rsp_zero", 64'(rsp_log[$]), 64'd0);
    chk("write_latency", 64'(last_lat), 64'd4);
    send(1'b0, 32'(DATE), 32'h0);
    wait_idle();
    chk("read_date", 64'(rsp_log[$]), 64'h15032024);
    wait_n = 0;
    send(1'b1, 32'(NUMBER_IN_GROUP), 32'h00000007);
    send(1'b1, 32'(SURNAME), 32'h4956414E);
    send(1'b0, 32'(NUMBER_IN_GROUP), 32'h0);
    send(1'b0, 32'(SURNAME), 32'h0);
    wait_idle();
    chk("b2b_read_group", 64'(rsp_log[rsp_log.size() - 2]), 64'h7);
    chk("b2b_read_surname", 64'(rsp_log[$]), 64'h4956414E);
    wait_n = 5;
    send(1'b1, 32'(NAME), 32'h4E414D45);
    send(1'b0, 32'(NAME), 32'h0);
    wait_idle();
    chk("wait_read_name", 64'(rsp_log[$]), 64'h4E414D45);
    chk("wait_latency", 64'(last_lat), 64'd8);
    wait_n = 0;
    stray = 1'b1;
    send(1'b0, 32'(SURNAME), 32'h0);
    wait_idle();
    chk("stray_read", 64'(rsp_log[$]), 64'h4956414E);
    chk("stray_latency", 64'(last_lat), 64'd3);
    stray = 1'b0;
    stall = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
    send(1'b0, 32'(DATE), 32'h0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = 32'(DATE);
    i = 0;
    do begin
      @(posedge PCLK);
      #1;
      i++;
    end while (!bus.rsp_valid && i < 100);
    stall = 1'b0;
    chk("timeout_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("timeout_rsp_err", 64'(bus.rsp_err), 64'd1);
    chk("timeout_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("timeout_psel", 64'(bus.PSEL), 64'd0);
    @(posedge PCLK);
    #1;
    bus.cmd_valid = 1'b0;
    wait_idle();
    chk("after_timeout_read", 64'(rsp_log[$]), 64'h15032024);
    stall = 1'b1;
    send(1'b0, 32'(DATE), 32'h0);
    repeat (5) @(posedge PCLK);
    #1;
`else
    send(1'b0, 32'(DATE), 32'h0);
    repeat (1000) @(posedge PCLK);
    #1;
    chk("stall_still_access", 64'({bus.PSEL, bus.PENABLE}), 64'd3);
`endif
    nr = n_rsp;
    PRESET = 1'b1;
    #1;
    chk("midreset_psel_penable", 64'({bus.PSEL, bus.PENABLE}), 64'd0);
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    stall = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("post_reset_ready", 64'(bus.cmd_ready), 64'd1);
    chk("no_rsp_for_aborted", 64'(n_rsp), 64'(nr));
    send(1'b0, 32'(DATE), 32'h0);
    wait_idle();
    chk("post_reset_read", 64'(rsp_log[$]), 64'h15032024);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
